dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
Data-memory responder serving the processor's dmem port: address_dmem, data, wren in; q_dmem out. Word-addressed synchronous RAM with registered read data. Sits in the wrapper beside the regfile and imem, and is the memory-side end of the dmem interface. Flags accesses outside the implemented address range with a sticky fault flag and captures the first offending address.

Parameters:
ADDR_WIDTH, 12, word-index bits; depth = 2**ADDR_WIDTH words
DATA_WIDTH, 32, word width; fixed 32 for processor compatibility

Ports:
clock  in  1  master clock, rising-edge active
reset  in  1  asynchronous, active-low; low = in reset
address_dmem  in  32  word address from processor
data  in  32  write data from processor
wren  in  1  write enable, sampled at rising edge
q_dmem  out  32  registered read data
fault  out  1  sticky out-of-range access flag
fault_addr  out  32  address of first faulting access
led  out  8  MMIO LED register; tied 0 without DMEM_MMIO_EN

Behaviour:
- Reset (reset=0, asynchronous): q_dmem=0, fault=0, fault_addr=0, led=0, MMIO counter=0. RAM array is not cleared.
- Writes and reads presented while reset is low are dropped.
- In-range test: address_dmem[31:ADDR_WIDTH]==0. Index = address_dmem[ADDR_WIDTH-1:0].
- Write: at a rising edge with wren=1 and in-range, mem[idx] <= data. Committed the same edge.
- Read: every rising edge, q_dmem <= mem[idx]. Latency is exactly 1 cycle: the address in cycle N appears on q_dmem in cycle N+1 and holds until the next edge.
- Read-during-write to the same index is write-first: q_dmem <= data.
- Reads occur on every edge, including when wren=1; there is no separate read enable.
- Out-of-range access, read or write, outside the MMIO window:
  - The write is dropped.
  - q_dmem <= 0.
  - fault <= 1 (sticky until reset).
  - fault_addr is loaded only if fault was 0 before the edge (first fault wins).
- Boundary: idx 2**ADDR_WIDTH-1 is in-range. 2**ADDR_WIDTH is out-of-range; it does not wrap to 0.
- No handshake: the responder is always ready and never stalls the processor.

Optional Feature:
DMEM_MMIO_EN
- Defined: memory-mapped window at 0xFFFF_FFF0 and 0xFFFF_FFF4. The window never faults.
- 0xFFFF_FFF0: free-running 32-bit cycle counter.
  - Increments every clock after reset and wraps 0xFFFF_FFFF -> 0.
  - A read returns the counter value held during the request cycle.
  - Writes are ignored.
- 0xFFFF_FFF4: 8-bit LED register.
  - A write loads data[7:0] into led at the edge.
  - A read returns {24'b0, led}; write-first applies.
- Other 0xFFFF_FFFx addresses are out-of-range.
- Undefined: both addresses are ordinary out-of-range (fault, q_dmem=0); led tied to 0; counter absent.

Decomposition:
- Package dmem_pkg:
  - MMIO_CYCLE_ADDR=32'hFFFF_FFF0
  - MMIO_LED_ADDR=32'hFFFF_FFF4
  - LED_WIDTH=8
  - default ADDR_WIDTH
- Sub-module dmem_mmio_regs holds the cycle counter, the LED register and the address decode. It is instantiated only under DMEM_MMIO_EN.
- The RAM array and fault logic live in dmem_responder.

Test Plan:
1. Release reset; write 0xDEADBEEF to addr 0x5; next cycle read 0x5 -> q_dmem=0xDEADBEEF one cycle after the read address, 0 before.
2. Same cycle: wren=1, addr 0x7, data 0x12345678 -> q_dmem=0x12345678 at the next edge, regardless of old mem[7].
3. ADDR_WIDTH=12: write 0x1 to addr 0x1000 -> fault=1, fault_addr=0x1000, q_dmem=0, mem[0] unchanged. Then read 0x2000 -> fault_addr stays 0x1000. Write/read 0xFFF -> works normally.
4. Drop reset asynchronously mid-cycle after test 3 -> q_dmem, fault, fault_addr go 0 immediately. After release, read 0x5 -> 0xDEADBEEF (RAM preserved). A write issued while reset is low is not committed.
5. With DMEM_MMIO_EN: read 0xFFFF_FFF0 two consecutive cycles -> values differ by exactly 1. Write 0xA5 to 0xFFFF_FFF4 -> led=0xA5 after the edge; readback 0x000000A5; fault stays 0.
6. Without DMEM_MMIO_EN: read 0xFFFF_FFF0 -> q_dmem=0, fault=1, fault_addr=0xFFFF_FFF0, led=0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared constants for the dmem responder slice.
// The MMIO addresses are only decoded when DMEM_MMIO_EN is defined.
package dmem_pkg;

    localparam int unsigned DEFAULT_ADDR_WIDTH = 12;
    localparam int unsigned LED_WIDTH          = 8;

    localparam logic [31:0] MMIO_CYCLE_ADDR = 32'hFFFF_FFF0;
    localparam logic [31:0] MMIO_LED_ADDR   = 32'hFFFF_FFF4;

endpackage

// File: rtl/dmem_mmio_regs.sv
// Memory-mapped registers beside the data RAM: a free-running cycle counter
// and an LED register, plus the decode of their two addresses.
// Instantiated by dmem_responder only when DMEM_MMIO_EN is defined.
module dmem_mmio_regs
    import dmem_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic [31:0]          i_address,
    input  logic [LED_WIDTH-1:0] i_wdata,
    input  logic                 i_wren,
    output logic                 o_hit,
    output logic [31:0]          o_rdata,
    output logic [LED_WIDTH-1:0] o_led
);

    logic [31:0]          r_cycle;
    logic [LED_WIDTH-1:0] r_led;
    logic                 w_cycleSel;
    logic                 w_ledSel;

    assign w_cycleSel = (i_address == MMIO_CYCLE_ADDR);
    assign w_ledSel   = (i_address == MMIO_LED_ADDR);
    assign o_hit      = w_cycleSel || w_ledSel;
    assign o_led      = r_led;

    // Counter runs on every clock once out of reset and wraps naturally.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cycle <= '0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
        end
    end

    // LED register takes the low byte of any write aimed at its address.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_led <= '0;
        end else if (i_wren && w_ledSel) begin
            r_led <= i_wdata;
        end
    end

    // Read mux: the counter value of the request cycle, or the LED byte
    // with the incoming write data forwarded so a write reads back at once.
    always_comb begin
        o_rdata = '0;
        if (w_cycleSel) begin
            o_rdata = r_cycle;
        end else if (w_ledSel) begin
            o_rdata = {{(32 - LED_WIDTH){1'b0}}, (i_wren ? i_wdata : r_led)};
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the processor dmem port: word-addressed RAM
// with one-cycle registered read data, write-first on collisions, and a
// sticky fault flag that records the first out-of-range address.
// Define DMEM_MMIO_EN to add the cycle-counter / LED register window.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [31:0]           address_dmem,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  wren,
    output logic [DATA_WIDTH-1:0] q_dmem,
    output logic                  fault,
    output logic [31:0]           fault_addr,
    output logic [LED_WIDTH-1:0]  led
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_q;
    logic                  r_fault;
    logic [31:0]           r_faultAddr;

    logic                  w_inRange;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic                  w_mmioHit;
    logic [DATA_WIDTH-1:0] w_mmioRdata;
    logic                  w_bad;

    // Addresses above the array do not alias back onto it.
    assign w_inRange = (address_dmem[31:ADDR_WIDTH] == '0);
    assign w_idx     = address_dmem[ADDR_WIDTH-1:0];
    assign w_bad     = !w_inRange && !w_mmioHit;

`ifdef DMEM_MMIO_EN
    dmem_mmio_regs u_mmio (
        .clock     (clock),
        .reset     (reset),
        .i_address (address_dmem),
        .i_wdata   (data[LED_WIDTH-1:0]),
        .i_wren    (wren),
        .o_hit     (w_mmioHit),
        .o_rdata   (w_mmioRdata),
        .o_led     (led)
    );
`else
    assign w_mmioHit   = 1'b0;
    assign w_mmioRdata = '0;
    assign led         = '0;
`endif

    // RAM contents survive reset; writes seen while in reset are discarded.
    always_ff @(posedge clock) begin
        if (reset && wren && w_inRange) begin
            r_mem[w_idx] <= data;
        end
    end

    // Read data every edge; a write to the same word is forwarded directly.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_q <= '0;
        end else if (w_inRange) begin
            r_q <= wren ? data : r_mem[w_idx];
        end else if (w_mmioHit) begin
            r_q <= w_mmioRdata;
        end else begin
            r_q <= '0;
        end
    end

    // Fault flag is sticky; only the first offending address is kept.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_fault     <= 1'b0;
            r_faultAddr <= '0;
        end else if (w_bad) begin
            r_fault <= 1'b1;
            if (!r_fault) begin
                r_faultAddr <= address_dmem;
            end
        end
    end

    assign q_dmem     = r_q;
    assign fault      = r_fault;
    assign fault_addr = r_faultAddr;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder. Directed scenarios followed by a
// randomized run scored against a word-array model of the memory map.
// Honours DMEM_MMIO_EN to select the MMIO or plain-fault expectations.
module tb_dmem_responder;

    logic        clock;
    logic        reset;
    logic [31:0] address_dmem;
    logic [31:0] data;
    logic        wren;
    logic [31:0] q_dmem;
    logic        fault;
    logic [31:0] fault_addr;
    logic [7:0]  led;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] mdlMem   [4096];
    bit          mdlValid [4096];
    bit          mdlFault;
    logic [31:0] mdlFaultAddr;
    logic [7:0]  mdlLed;

    dmem_responder dut (
        .clock        (clock),
        .reset        (reset),
        .address_dmem (address_dmem),
        .data         (data),
        .wren         (wren),
        .q_dmem       (q_dmem),
        .fault        (fault),
        .fault_addr   (fault_addr),
        .led          (led)
    );

    // 10 ns clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Present one request, let one rising edge consume it, settle 1 ns.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d, input logic w);
        address_dmem = a;
        data         = d;
        wren         = w;
        @(posedge clock);
        #1;
    endtask

    // Pulse reset low for a couple of edges and release between edges.
    task automatic pulseReset();
        reset = 1'b0;
        wren  = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b1;
        mdlFault     = 0;
        mdlFaultAddr = '0;
        mdlLed       = '0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        address_dmem = '0;
        data = '0;
        wren = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if (q_dmem !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_q: got %h expected %h", q_dmem, 32'h0);
        end
        checks++;
        if (fault !== 1'b0 || fault_addr !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_fault: got %b/%h expected 0/00000000", fault, fault_addr);
        end
        checks++;
        if (led !== 8'h0) begin
            errors++;
            $display("[TB] FAIL reset_led: got %h expected 00", led);
        end
        reset = 1'b1;
        mdlFault = 0;
        mdlFaultAddr = '0;
        mdlLed = '0;
    endtask

    task automatic test_write_read();
        applyStimulus(32'h0, 32'hCAFE_0000, 1'b1);
        applyStimulus(32'h8, 32'h0, 1'b1);
        applyStimulus(32'h5, 32'hDEAD_BEEF, 1'b1);
        mdlMem[0] = 32'hCAFE_0000; mdlValid[0] = 1;
        mdlMem[8] = 32'h0;         mdlValid[8] = 1;
        mdlMem[5] = 32'hDEAD_BEEF; mdlValid[5] = 1;
        applyStimulus(32'h8, 32'h1111_1111, 1'b0);
        checks++;
        if (q_dmem !== 32'h0) begin
            errors++;
            $display("[TB] FAIL read_before: got %h expected %h", q_dmem, 32'h0);
        end
        // address 5 presented now; q_dmem must still show the old word until the edge
        address_dmem = 32'h5;
        #2;
        checks++;
        if (q_dmem !== 32'h0) begin
            errors++;
            $display("[TB] FAIL read_latency: got %h expected %h", q_dmem, 32'h0);
        end
        applyStimulus(32'h5, 32'h0, 1'b0);
        checks++;
        if (q_dmem !== 32'hDEAD_BEEF) begin
            errors++;
            $display("[TB] FAIL read_5: got %h expected %h", q_dmem, 32'hDEAD_BEEF);
        end
        address_dmem = 32'h0;
        #3;
        checks++;
        if (q_dmem !== 32'hDEAD_BEEF) begin
            errors++;
            $display("[TB] FAIL read_hold: got %h expected %h", q_dmem, 32'hDEAD_BEEF);
        end
        applyStimulus(32'h0, 32'h0, 1'b0);
        checks++;
        if (q_dmem !== 32'hCAFE_0000) begin
            errors++;
            $display("[TB] FAIL read_0: got %h expected %h", q_dmem, 32'hCAFE_0000);
        end
    endtask

    task automatic test_write_first();
        applyStimulus(32'h7, 32'h5555_AAAA, 1'b1);
        applyStimulus(32'h7, 32'h1234_5678, 1'b1);
        mdlMem[7] = 32'h1234_5678; mdlValid[7] = 1;
        checks++;
        if (q_dmem !== 32'h1234_5678) begin
            errors++;
            $display("[TB] FAIL write_first: got %h expected %h", q_dmem, 32'h1234_5678);
        end
        applyStimulus(32'h7, 32'h0, 1'b0);
        checks++;
        if (q_dmem !== 32'h1234_5678) begin
            errors++;
            $display("[TB] FAIL write_first_commit: got %h expected %h", q_dmem, 32'h1234_5678);
        end
    endtask

    task automatic test_out_of_range();
        applyStimulus(32'h1000, 32'h1, 1'b1);
        checks++;
        if (fault !== 1'b1 || fault_addr !== 32'h1000 || q_dmem !== 32'h0) begin
            errors++;
            $display("[TB] FAIL oor_write: got fault=%b addr=%h q=%h expected 1/00001000/00000000", fault, fault_addr, q_dmem);
        end
        applyStimulus(32'h0, 32'h0, 1'b0);
        checks++;
        if (q_dmem !== 32'hCAFE_0000) begin
            errors++;
            $display("[TB] FAIL oor_no_wrap: got %h expected %h", q_dmem, 32'hCAFE_0000);
        end
        applyStimulus(32'h2000, 32'h0, 1'b0);
        checks++;
        if (fault !== 1'b1 || fault_addr !== 32'h1000 || q_dmem !== 32'h0) begin
            errors++;
            $display("[TB] FAIL oor_sticky: got fault=%b addr=%h q=%h expected 1/00001000/00000000", fault, fault_addr, q_dmem);
        end
        applyStimulus(32'hFFF, 32'h0BAD_F00D, 1'b1);
        applyStimulus(32'h5, 32'h0, 1'b0);
        applyStimulus(32'hFFF, 32'h0, 1'b0);
        mdlMem[12'hFFF] = 32'h0BAD_F00D; mdlValid[12'hFFF] = 1;
        checks++;
        if (q_dmem !== 32'h0BAD_F00D || fault_addr !== 32'h1000) begin
            errors++;
            $display("[TB] FAIL top_word: got q=%h addr=%h expected 0badf00d/00001000", q_dmem, fault_addr);
        end
    endtask

    task automatic test_async_reset();
        @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        checks++;
        if (q_dmem !== 32'h0 || fault !== 1'b0 || fault_addr !== 32'h0) begin
            errors++;
            $display("[TB] FAIL async_reset: got q=%h fault=%b addr=%h expected all zero", q_dmem, fault, fault_addr);
        end
        address_dmem = 32'h5;
        data = 32'h6666_7777;
        wren = 1'b1;
        @(posedge clock);
        #1;
        wren = 1'b0;
        reset = 1'b1;
        mdlFault = 0;
        mdlFaultAddr = '0;
        mdlLed = '0;
        applyStimulus(32'h5, 32'h0, 1'b0);
        checks++;
        if (q_dmem !== 32'hDEAD_BEEF) begin
            errors++;
            $display("[TB] FAIL ram_preserved: got %h expected %h", q_dmem, 32'hDEAD_BEEF);
        end
    endtask

`ifdef DMEM_MMIO_EN
    task automatic test_mmio();
        logic [31:0] first;
        pulseReset();
        applyStimulus(32'hFFFF_FFF0, 32'h0, 1'b0);
        first = q_dmem;
        applyStimulus(32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b1);
        checks++;
        if (q_dmem - first !== 32'd1) begin
            errors++;
            $display("[TB] FAIL counter_step: got %h then %h expected a step of 1", first, q_dmem);
        end
        applyStimulus(32'hFFFF_FFF4, 32'h1234_56A5, 1'b1);
        checks++;
        if (led !== 8'hA5 || q_dmem !== 32'h0000_00A5) begin
            errors++;
            $display("[TB] FAIL led_write: got led=%h q=%h expected a5/000000a5", led, q_dmem);
        end
        applyStimulus(32'hFFFF_FFF4, 32'h0, 1'b0);
        checks++;
        if (q_dmem !== 32'h0000_00A5 || fault !== 1'b0) begin
            errors++;
            $display("[TB] FAIL led_read: got q=%h fault=%b expected 000000a5/0", q_dmem, fault);
        end
        mdlLed = 8'hA5;
        applyStimulus(32'hFFFF_FFF8, 32'h0, 1'b0);
        checks++;
        if (fault !== 1'b1 || fault_addr !== 32'hFFFF_FFF8 || q_dmem !== 32'h0) begin
            errors++;
            $display("[TB] FAIL mmio_hole: got fault=%b addr=%h q=%h expected 1/fffffff8/00000000", fault, fault_addr, q_dmem);
        end
    endtask
`else
    task automatic test_no_mmio();
        pulseReset();
        applyStimulus(32'hFFFF_FFF4, 32'hA5, 1'b1);
        applyStimulus(32'hFFFF_FFF0, 32'h0, 1'b0);
        checks++;
        if (q_dmem !== 32'h0 || fault !== 1'b1 || fault_addr !== 32'hFFFF_FFF4 || led !== 8'h0) begin
            errors++;
            $display("[TB] FAIL no_mmio: got q=%h fault=%b addr=%h led=%h expected 0/1/fffffff4/00", q_dmem, fault, fault_addr, led);
        end
    endtask
`endif

    // Random traffic scored against the word-array model.
    task automatic test_random();
        logic [31:0] pool [16];
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] expQ;
        logic        w;
        bit          inR;
        bit          qKnown;
        int          r;
        pulseReset();
        pool[0] = 32'h0;
        pool[1] = 32'hFFF;
        for (int i = 2; i < 16; i++) pool[i] = $urandom_range(0, 4095);
        for (int i = 0; i < 16; i++) begin
            d = $urandom;
            applyStimulus(pool[i], d, 1'b1);
            mdlMem[pool[i]] = d;
            mdlValid[pool[i]] = 1;
        end
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 99);
            d = $urandom;
            w = 1'($urandom_range(0, 1));
            if (r < 8) begin
                a = $urandom | 32'h0001_0000;
                if (a[31:4] == 28'hFFFF_FFF) a = 32'h0000_1000 + 32'(r);
            end
`ifdef DMEM_MMIO_EN
            else if (r < 16) a = 32'hFFFF_FFF4;
`endif
            else a = pool[$urandom_range(0, 15)];
            inR = (a < 32'd4096);
            qKnown = 1;
            if (inR) begin
                if (w) begin
                    mdlMem[a] = d;
                    mdlValid[a] = 1;
                end
                qKnown = mdlValid[a];
                expQ = mdlMem[a];
            end
`ifdef DMEM_MMIO_EN
            else if (a == 32'hFFFF_FFF4) begin
                if (w) mdlLed = d[7:0];
                expQ = {24'h0, mdlLed};
            end
`endif
            else begin
                expQ = 32'h0;
                if (!mdlFault) mdlFaultAddr = a;
                mdlFault = 1;
            end
            applyStimulus(a, d, w);
            if (qKnown) begin
                checks++;
                if (q_dmem !== expQ) begin
                    errors++;
                    $display("[TB] FAIL rand_q[%0d]: addr %h got %h expected %h", n, a, q_dmem, expQ);
                end
            end
            checks++;
            if (fault !== mdlFault || fault_addr !== mdlFaultAddr || led !== mdlLed) begin
                errors++;
                $display("[TB] FAIL rand_status[%0d]: got fault=%b addr=%h led=%h expected %b/%h/%h",
                         n, fault, fault_addr, led, mdlFault, mdlFaultAddr, mdlLed);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mdlValid[i] = 0;
        mdlFault = 0;
        mdlFaultAddr = '0;
        mdlLed = '0;
        test_reset();
        test_write_read();
        test_write_first();
        test_out_of_range();
        test_async_reset();
`ifdef DMEM_MMIO_EN
        test_mmio();
`else
        test_no_mmio();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
